// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage and its condition evaluator:
// opcodes, NOP encoding, instruction field layout, condition codes, FSM states.
package id_stage_pkg;

    localparam logic [6:0]  OP_B     = 7'b1100000;
    localparam logic [6:0]  OP_BCOND = 7'b1100001;
    localparam logic [6:0]  OP_BR    = 7'b1100010;
    localparam logic [6:0]  OP_LD    = 7'b1000000;

    localparam logic [31:0] NOP_WORD = 32'hC8000000;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 25;
    localparam int RD_HI  = 24;
    localparam int RD_LO  = 22;
    localparam int RS1_HI = 21;
    localparam int RS1_LO = 19;
    localparam int RS2_HI = 18;
    localparam int RS2_LO = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Packed view of an instruction word; the branch condition shares the rd slot.
    typedef struct packed {
        logic [OPC_HI-OPC_LO:0] opcode;
        logic [RD_HI-RD_LO:0]   rd;
        logic [RS1_HI-RS1_LO:0] rs1;
        logic [RS2_HI-RS2_LO:0] rs2;
        logic [IMM_HI-IMM_LO:0] imm16;
    } instr_t;

    typedef enum logic [2:0] {
        CC_EQ = 3'b000,
        CC_NE = 3'b001,
        CC_LT = 3'b010,
        CC_GE = 3'b011,
        CC_CS = 3'b100,
        CC_CC = 3'b101,
        CC_MI = 3'b110,
        CC_AL = 3'b111
    } cond_t;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_HAZ = 2'd1,
        ST_BR  = 2'd2
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_cond_eval.sv
// Combinational branch condition evaluator: 3-bit condition code against {N,Z,C,V}.
// Shared between ID (conditional branch resolve) and EX.
module cond_eval
    import id_stage_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[3];
    assign w_z = i_flags[2];
    assign w_c = i_flags[1];
    assign w_v = i_flags[0];

    always_comb begin
        o_taken = 1'b0;
        case (cond_t'(i_cond))
            CC_EQ:   o_taken = w_z;
            CC_NE:   o_taken = ~w_z;
            CC_LT:   o_taken = w_n ^ w_v;
            CC_GE:   o_taken = ~(w_n ^ w_v);
            CC_CS:   o_taken = w_c;
            CC_CC:   o_taken = ~w_c;
            CC_MI:   o_taken = w_n;
            CC_AL:   o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: one-cycle registered decode, BCOND resolve, load-use/flag stalls.
// Optional perf counters (stall_count, br_count) enabled by defining ID_PERF_CNT_EN.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          REG_AW   = 3,
    parameter logic [31:0] NOP_WORD = id_stage_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instruction_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        flags_in,
    input  logic              ex_sets_flags,
    output logic              stall,
    output logic [6:0]        opcode_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [REG_AW-1:0] rs1_out,
    output logic [REG_AW-1:0] rs2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic              id_valid,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic [31:0]       stall_count,
    output logic [31:0]       br_count
);

    state_t            r_state;
    logic [6:0]        r_opcode;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [DATA_W-1:0] r_imm;
    logic              r_vld;
    logic              r_br_taken;
    logic [DATA_W-1:0] r_br_target;

    instr_t            w_in;
    instr_t            w_nop;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_nop_imm;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_target;
    logic              w_active;
    logic              w_is_bcond;
    logic              w_lu_haz;
    logic              w_flag_haz;
    logic              w_cond_taken;
    logic              w_take;
    logic              w_bubble;
    logic              w_stall;

    assign w_in      = instr_t'(instruction_in);
    assign w_nop     = instr_t'(NOP_WORD);
    assign w_imm     = {{(DATA_W-16){w_in.imm16[15]}}, w_in.imm16};
    assign w_nop_imm = {{(DATA_W-16){w_nop.imm16[15]}}, w_nop.imm16};

    // Branch target is word-aligned; the add wraps silently.
    assign w_sum    = pc_in + w_imm;
    assign w_target = w_sum & {{(DATA_W-2){1'b1}}, 2'b00};

    // The BR cycle carries IF's injected NOP, so nothing is evaluated then.
    assign w_active   = (r_state != ST_BR);
    assign w_is_bcond = (w_in.opcode == OP_BCOND);
    assign w_lu_haz   = (r_state == ST_RUN) && r_vld && (r_opcode == OP_LD) &&
                        ((r_rd == w_in.rs1) || (r_rd == w_in.rs2));
    assign w_flag_haz = w_active && w_is_bcond && ex_sets_flags;

    cond_eval u_cond_eval (
        .i_cond  (w_in.rd),
        .i_flags (flags_in),
        .o_taken (w_cond_taken)
    );

    assign w_take   = w_active && !w_lu_haz && !w_flag_haz && w_is_bcond && w_cond_taken;
    assign w_bubble = !w_active || w_lu_haz || w_flag_haz || w_is_bcond;
    assign w_stall  = !reset && w_active && (w_lu_haz || w_flag_haz);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_opcode    <= w_nop.opcode;
            r_rd        <= w_nop.rd;
            r_rs1       <= w_nop.rs1;
            r_rs2       <= w_nop.rs2;
            r_imm       <= w_nop_imm;
            r_vld       <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_br_taken <= w_take;
            if (w_take) begin
                r_br_target <= w_target;
            end

            if (w_bubble) begin
                r_opcode <= w_nop.opcode;
                r_rd     <= w_nop.rd;
                r_rs1    <= w_nop.rs1;
                r_rs2    <= w_nop.rs2;
                r_imm    <= w_nop_imm;
                r_vld    <= 1'b0;
            end else begin
                r_opcode <= w_in.opcode;
                r_rd     <= w_in.rd;
                r_rs1    <= w_in.rs1;
                r_rs2    <= w_in.rs2;
                r_imm    <= w_imm;
                r_vld    <= 1'b1;
            end

            // Priority: load-use, then flag hazard (stays RUN), then branch resolve.
            case (r_state)
                ST_RUN: begin
                    if (w_lu_haz)
                        r_state <= ST_HAZ;
                    else if (w_flag_haz)
                        r_state <= ST_RUN;
                    else if (w_is_bcond)
                        r_state <= ST_BR;
                    else
                        r_state <= ST_RUN;
                end
                ST_HAZ: begin
                    if (!w_flag_haz && w_is_bcond)
                        r_state <= ST_BR;
                    else
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_br_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_br_cnt    <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFFFFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_take && (r_br_cnt != 32'hFFFFFFFF))
                r_br_cnt <= r_br_cnt + 32'd1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign br_count    = r_br_cnt;
`else
    assign stall_count = '0;
    assign br_count    = '0;
`endif

    assign stall      = w_stall;
    assign opcode_out = r_opcode;
    assign rd_out     = r_rd;
    assign rs1_out    = r_rs1;
    assign rs2_out    = r_rs2;
    assign imm_out    = r_imm;
    assign id_valid   = r_vld;
    assign br_taken   = r_br_taken;
    assign br_target  = r_br_target;

endmodule

// File: tb/tb_id_stage.sv
// Table-driven bench for id_stage with a one-deep scoreboard for the registered outputs.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_in;
    logic [31:0] pc_in;
    logic [3:0]  flags_in;
    logic        ex_sets_flags;
    logic        stall;
    logic [6:0]  opcode_out;
    logic [2:0]  rd_out, rs1_out, rs2_out;
    logic [31:0] imm_out;
    logic        id_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] stall_count, br_count;

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_in (instruction_in),
        .pc_in          (pc_in),
        .flags_in       (flags_in),
        .ex_sets_flags  (ex_sets_flags),
        .stall          (stall),
        .opcode_out     (opcode_out),
        .rd_out         (rd_out),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out),
        .imm_out        (imm_out),
        .id_valid       (id_valid),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .stall_count    (stall_count),
        .br_count       (br_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  flags;
        logic        exf;
        logic        stall;
        logic        vld;
        logic [31:0] word;
        logic        brt;
        logic [31:0] tgt;
    } vec_t;

    typedef struct {
        int          idx;
        logic        vld;
        logic [31:0] word;
        logic        brt;
        logic [31:0] tgt;
        logic [31:0] scnt;
        logic [31:0] bcnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic add(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] flags,
                       input logic exf, input logic st, input logic vld, input logic [31:0] word,
                       input logic brt, input logic [31:0] tgt);
        vec_t v;
        v.instr = instr; v.pc = pc; v.flags = flags; v.exf = exf;
        v.stall = st; v.vld = vld; v.word = word; v.brt = brt; v.tgt = tgt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] w, input logic vld);
        logic [31:0] wl;
        wl = w;
        chk({tag, ".vld"},    {31'd0, id_valid}, {31'd0, vld});
        chk({tag, ".opcode"}, {25'd0, opcode_out}, {25'd0, wl[31:25]});
        chk({tag, ".rd"},     {29'd0, rd_out},  {29'd0, wl[24:22]});
        chk({tag, ".rs1"},    {29'd0, rs1_out}, {29'd0, wl[21:19]});
        chk({tag, ".rs2"},    {29'd0, rs2_out}, {29'd0, wl[18:16]});
        chk({tag, ".imm"},    imm_out, {{16{wl[15]}}, wl[15:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w_ld3, w_add, bc_eq, bc_eq2, bc_al, bc_cc, w_b, w_ld2, bc_lt, w_br;
        logic [31:0] m_scnt, m_bcnt;
        exp_t        e;

        w_ld3  = mk(OP_LD, 3'd3, 3'd1, 3'd2, 16'h8000);
        w_add  = mk(7'h01, 3'd4, 3'd3, 3'd5, 16'h0007);
        bc_eq  = mk(OP_BCOND, 3'b000, 3'd0, 3'd0, 16'hFFFC);
        bc_eq2 = mk(OP_BCOND, 3'b000, 3'd0, 3'd0, 16'h0013);
        bc_al  = mk(OP_BCOND, 3'b111, 3'd0, 3'd0, 16'h8000);
        bc_cc  = mk(OP_BCOND, 3'b101, 3'd0, 3'd0, 16'h0004);
        w_b    = mk(OP_B, 3'd0, 3'd1, 3'd1, 16'h0005);
        w_ld2  = mk(OP_LD, 3'd2, 3'd0, 3'd0, 16'h0000);
        bc_lt  = mk(OP_BCOND, 3'b010, 3'd0, 3'd2, 16'h0100);
        w_br   = mk(OP_BR, 3'd1, 3'd2, 3'd3, 16'hFFFF);

        //   instr     pc          flags    exf stall vld word      brt tgt
        add(32'h0,    32'h000,    4'b0000, 0,  0,    1,  32'h0,    0,  32'h0);
        add(w_ld3,    32'h004,    4'b0000, 0,  0,    1,  w_ld3,    0,  32'h0);
        add(w_add,    32'h008,    4'b0000, 0,  1,    0,  NOP_WORD, 0,  32'h0);
        add(w_add,    32'h008,    4'b0000, 0,  0,    1,  w_add,    0,  32'h0);
        add(NOP_WORD, 32'h00C,    4'b0000, 0,  0,    1,  NOP_WORD, 0,  32'h0);
        add(bc_eq,    32'h100,    4'b0100, 0,  0,    0,  NOP_WORD, 1,  32'h0FC);
        add(NOP_WORD, 32'h104,    4'b0100, 1,  0,    0,  NOP_WORD, 0,  32'h0);
        add(bc_eq,    32'h100,    4'b0000, 0,  0,    0,  NOP_WORD, 0,  32'h0);
        add(NOP_WORD, 32'h104,    4'b0000, 0,  0,    0,  NOP_WORD, 0,  32'h0);
        add(bc_eq2,   32'h200,    4'b0000, 1,  1,    0,  NOP_WORD, 0,  32'h0);
        add(bc_eq2,   32'h200,    4'b0000, 1,  1,    0,  NOP_WORD, 0,  32'h0);
        add(bc_eq2,   32'h200,    4'b0100, 0,  0,    0,  NOP_WORD, 1,  32'h210);
        add(NOP_WORD, 32'h204,    4'b0000, 0,  0,    0,  NOP_WORD, 0,  32'h0);
        add(bc_al,    32'h1000,   4'b0000, 0,  0,    0,  NOP_WORD, 1,  32'hFFFF9000);
        add(NOP_WORD, 32'h1004,   4'b0000, 0,  0,    0,  NOP_WORD, 0,  32'h0);
        add(bc_cc,    32'h2000,   4'b0010, 0,  0,    0,  NOP_WORD, 0,  32'h0);
        add(NOP_WORD, 32'h2004,   4'b0010, 0,  0,    0,  NOP_WORD, 0,  32'h0);
        add(w_b,      32'h2008,   4'b0000, 0,  0,    1,  w_b,      0,  32'h0);
        add(w_ld2,    32'h200C,   4'b0000, 0,  0,    1,  w_ld2,    0,  32'h0);
        add(bc_lt,    32'h300,    4'b0000, 1,  1,    0,  NOP_WORD, 0,  32'h0);
        add(bc_lt,    32'h300,    4'b0000, 1,  1,    0,  NOP_WORD, 0,  32'h0);
        add(bc_lt,    32'h300,    4'b1000, 0,  0,    0,  NOP_WORD, 1,  32'h400);
        add(NOP_WORD, 32'h304,    4'b1000, 0,  0,    0,  NOP_WORD, 0,  32'h0);
        add(w_br,     32'h308,    4'b0000, 0,  0,    1,  w_br,     0,  32'h0);

        reset = 1'b1;
        instruction_in = 32'h0; pc_in = 32'h0; flags_in = 4'h0; ex_sets_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_fields("reset", NOP_WORD, 1'b0);
        chk("reset.stall", {31'd0, stall}, 32'd0);
        chk("reset.br_taken", {31'd0, br_taken}, 32'd0);
        chk("reset.br_target", br_target, 32'd0);
        chk("reset.stall_count", stall_count, 32'd0);
        chk("reset.br_count", br_count, 32'd0);
        reset = 1'b0;

        m_scnt = 0;
        m_bcnt = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            instruction_in = tbl[i].instr;
            pc_in          = tbl[i].pc;
            flags_in       = tbl[i].flags;
            ex_sets_flags  = tbl[i].exf;
            @(negedge clk);
            chk($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, tbl[i].stall});
            m_scnt = m_scnt + {31'd0, tbl[i].stall};
            m_bcnt = m_bcnt + {31'd0, tbl[i].brt};
            e.idx  = i;
            e.vld  = tbl[i].vld;
            e.word = tbl[i].word;
            e.brt  = tbl[i].brt;
            e.tgt  = tbl[i].tgt;
`ifdef ID_PERF_CNT_EN
            e.scnt = m_scnt;
            e.bcnt = m_bcnt;
`else
            e.scnt = 32'd0;
            e.bcnt = 32'd0;
`endif
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk_fields($sformatf("v%0d", e.idx), e.word, e.vld);
            chk($sformatf("v%0d.br_taken", e.idx), {31'd0, br_taken}, {31'd0, e.brt});
            if (e.brt)
                chk($sformatf("v%0d.br_target", e.idx), br_target, e.tgt);
            chk($sformatf("v%0d.stall_count", e.idx), stall_count, e.scnt);
            chk($sformatf("v%0d.br_count", e.idx), br_count, e.bcnt);
        end

        // Reset asserted while the FSM sits in BR with a live pulse.
        instruction_in = bc_al; pc_in = 32'h40; flags_in = 4'h0; ex_sets_flags = 1'b0;
        @(posedge clk);
        #1;
        chk("rstbr.pulse_before", {31'd0, br_taken}, 32'd1);
        chk("rstbr.target_before", br_target, 32'hFFFF8040);
        #2;
        reset = 1'b1;
        #1;
        chk("rstbr.br_taken", {31'd0, br_taken}, 32'd0);
        chk("rstbr.id_valid", {31'd0, id_valid}, 32'd0);
        chk("rstbr.opcode", {25'd0, opcode_out}, {25'd0, NOP_WORD[31:25]});
        chk("rstbr.stall_count", stall_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        instruction_in = w_add;
        @(posedge clk);
        #1;
        chk("rstbr.run_vld", {31'd0, id_valid}, 32'd1);
        chk("rstbr.run_rs1", {29'd0, rs1_out}, 32'd3);
        chk("rstbr.no_pulse", {31'd0, br_taken}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
